// File: rtl/fare_pkg.sv
// Shared types and defaults for the fare ledger: FSM states, account record, fare rule.
package fare_pkg;

  localparam logic [11:0] FARE_DEFAULT    = 12'd250;
  localparam int          TIMEOUT_DEFAULT = 8;
  localparam int          NACC_DEFAULT    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    PRESENT,
    WAIT,
    DEBIT
  } fare_state_t;

  typedef struct packed {
    logic        active;
    logic        monthly;
    logic [11:0] bal;
  } acct_t;

  // An account can pay a ride when it is active and holds at least one fare.
  // Equality counts as enough; the compare is plain unsigned 12-bit.
  function automatic logic can_pay(input acct_t a, input logic [11:0] fare);
    return a.active && (a.bal >= fare);
  endfunction

endpackage

// File: rtl/fare_ledger_if.sv
// Bundle of the reader, gate and admin signals around the fare ledger.
// The master side is the outside world (reader, gate FSM, admin console);
// the slave side is the ledger itself.
interface fare_ledger_if;

  logic        tap_valid;
  logic [3:0]  tap_id;
  logic        reduce_bal;
  logic        adm_we;
  logic [3:0]  adm_id;
  logic        adm_active;
  logic        adm_monthly;
  logic [11:0] adm_bal;

  logic        nfc;
  logic        card_active;
  logic        monthly;
  logic        fund_enough;
  logic [11:0] bal_out;
  logic        busy;
  logic        tap_drop;
  logic        adm_err;

  modport master (
    output tap_valid, tap_id, reduce_bal,
    output adm_we, adm_id, adm_active, adm_monthly, adm_bal,
    input  nfc, card_active, monthly, fund_enough, bal_out,
    input  busy, tap_drop, adm_err
  );

  modport slave (
    input  tap_valid, tap_id, reduce_bal,
    input  adm_we, adm_id, adm_active, adm_monthly, adm_bal,
    output nfc, card_active, monthly, fund_enough, bal_out,
    output busy, tap_drop, adm_err
  );

endinterface

// File: rtl/fare_acct_rf.sv
// Account table: NACC records, one synchronous write port, one asynchronous read port.
// Reset wipes every record, and it wins over a write in the same cycle so an
// aborted debit never lands in the table.
module fare_acct_rf
  import fare_pkg::*;
#(
  parameter int NACC = NACC_DEFAULT,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  acct_t         wdata,
  input  logic [AW-1:0] raddr,
  output acct_t         rdata
);

  acct_t mem_q [NACC];

  // Table storage: clear on reset, otherwise commit the single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NACC; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fare_ledger.sv
// Fare ledger: looks up a tapped card, presents its status to the gate FSM for one
// nfc pulse, then waits a bounded time for a debit request and charges one fare.
// Admin writes are only taken while idle; anything arriving mid-transaction is
// refused with a one-cycle pulse and leaves the transaction alone.
module fare_ledger
  import fare_pkg::*;
#(
  parameter logic [11:0] FARE    = FARE_DEFAULT,
  parameter int          TIMEOUT = TIMEOUT_DEFAULT,
  parameter int          NACC    = NACC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fare_ledger_if.slave  bus
);

  // Last WAIT count before giving up on the gate.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  fare_state_t state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  acct_t       acct_q, acct_d;

  logic        nfc_q, nfc_d;
  logic        card_active_q, card_active_d;
  logic        monthly_q, monthly_d;
  logic        fund_enough_q, fund_enough_d;
  logic [11:0] bal_out_q, bal_out_d;
  logic        busy_q, busy_d;
  logic        tap_drop_q, tap_drop_d;
  logic        adm_err_q, adm_err_d;

  logic        rf_we;
  logic [3:0]  rf_waddr;
  acct_t       rf_wdata;
  acct_t       rf_rdata;
  logic [11:0] debited_bal;

  assign debited_bal = acct_q.bal - FARE;

  fare_acct_rf #(
    .NACC (NACC),
    .AW   (4)
  ) u_acct_rf (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (id_q),
    .rdata (rf_rdata)
  );

  // Next-state logic: transaction sequencing, table write port muxing and output staging.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    acct_d        = acct_q;
    nfc_d         = 1'b0;
    card_active_d = card_active_q;
    monthly_d     = monthly_q;
    fund_enough_d = fund_enough_q;
    bal_out_d     = bal_out_q;
    tap_drop_d    = 1'b0;
    adm_err_d     = 1'b0;

    rf_we            = 1'b0;
    rf_waddr         = bus.adm_id;
    rf_wdata.active  = bus.adm_active;
    rf_wdata.monthly = bus.adm_monthly;
    rf_wdata.bal     = bus.adm_bal;

    if (state_q != IDLE) begin
      tap_drop_d = bus.tap_valid;
      adm_err_d  = bus.adm_we;
    end

    case (state_q)
      IDLE: begin
        // The admin write lands on this edge, so a same-cycle tap of the
        // same account sees the new record when LOOKUP reads the table.
        rf_we = bus.adm_we;
        if (bus.tap_valid) begin
          id_d    = bus.tap_id;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        acct_d        = rf_rdata;
        card_active_d = rf_rdata.active;
        monthly_d     = rf_rdata.monthly;
        fund_enough_d = can_pay(rf_rdata, FARE);
        bal_out_d     = rf_rdata.bal;
        nfc_d         = 1'b1;
        state_d       = PRESENT;
      end

      PRESENT: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.reduce_bal) begin
          state_d = DEBIT;
        end else if (cnt_q == WAIT_LAST) begin
          state_d       = IDLE;
          cnt_d         = '0;
          card_active_d = 1'b0;
          monthly_d     = 1'b0;
          fund_enough_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DEBIT: begin
        // Monthly passes ride free and short balances are never charged,
        // so the subtraction can never wrap.
        if (can_pay(acct_q, FARE) && !acct_q.monthly) begin
          rf_we            = 1'b1;
          rf_waddr         = id_q;
          rf_wdata.active  = acct_q.active;
          rf_wdata.monthly = acct_q.monthly;
          rf_wdata.bal     = debited_bal;
          acct_d.bal       = debited_bal;
          bal_out_d        = debited_bal;
        end
        state_d       = IDLE;
        cnt_d         = '0;
        card_active_d = 1'b0;
        monthly_d     = 1'b0;
        fund_enough_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset returns to IDLE with every output cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      id_q          <= '0;
      cnt_q         <= '0;
      acct_q        <= '0;
      nfc_q         <= 1'b0;
      card_active_q <= 1'b0;
      monthly_q     <= 1'b0;
      fund_enough_q <= 1'b0;
      bal_out_q     <= '0;
      busy_q        <= 1'b0;
      tap_drop_q    <= 1'b0;
      adm_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      acct_q        <= acct_d;
      nfc_q         <= nfc_d;
      card_active_q <= card_active_d;
      monthly_q     <= monthly_d;
      fund_enough_q <= fund_enough_d;
      bal_out_q     <= bal_out_d;
      busy_q        <= busy_d;
      tap_drop_q    <= tap_drop_d;
      adm_err_q     <= adm_err_d;
    end
  end

  assign bus.nfc         = nfc_q;
  assign bus.card_active = card_active_q;
  assign bus.monthly     = monthly_q;
  assign bus.fund_enough = fund_enough_q;
  assign bus.bal_out     = bal_out_q;
  assign bus.busy        = busy_q;
  assign bus.tap_drop    = tap_drop_q;
  assign bus.adm_err     = adm_err_q;

endmodule

// File: tb/tb_fare_ledger.sv
// Bench for fare_ledger: directed scenarios followed by random transactions,
// all checked against a plain array model of the account table.
module tb_fare_ledger;

  localparam logic [11:0] FARE    = 12'd250;
  localparam int          TIMEOUT = 8;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  logic        m_act [16];
  logic        m_mon [16];
  logic [11:0] m_bal [16];

  fare_ledger_if bus ();

  fare_ledger #(
    .FARE    (FARE),
    .TIMEOUT (TIMEOUT),
    .NACC    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      m_act[i] = 1'b0;
      m_mon[i] = 1'b0;
      m_bal[i] = 12'd0;
    end
  endtask

  task automatic checkIdle(input string tag, input logic [11:0] expBal);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_nfc"}, bus.nfc, 0);
    checkOutput({tag, "_active"}, bus.card_active, 0);
    checkOutput({tag, "_monthly"}, bus.monthly, 0);
    checkOutput({tag, "_fund"}, bus.fund_enough, 0);
    checkOutput({tag, "_bal"}, bus.bal_out, expBal);
    checkOutput({tag, "_drop"}, bus.tap_drop, 0);
    checkOutput({tag, "_err"}, bus.adm_err, 0);
  endtask

  task automatic adminWrite(input logic [3:0] id, input logic act, input logic mon,
                            input logic [11:0] bal);
    bus.adm_we      = 1'b1;
    bus.adm_id      = id;
    bus.adm_active  = act;
    bus.adm_monthly = mon;
    bus.adm_bal     = bal;
    tick();
    bus.adm_we = 1'b0;
    m_act[id]  = act;
    m_mon[id]  = mon;
    m_bal[id]  = bal;
    checkOutput("adm_err_idle", bus.adm_err, 0);
    checkOutput("busy_after_adm", bus.busy, 0);
  endtask

  // One full card transaction starting from IDLE. reduceAt is the WAIT cycle
  // (0 = first cycle after nfc) that carries reduce_bal, or -1 for none.
  task automatic applyStimulus(input logic [3:0] id, input int reduceAt, input bit disturb,
                               input bit earlyReduce, input bit admWith, input logic [3:0] admId,
                               input logic admAct, input logic admMon, input logic [11:0] admBal);
    logic        eAct;
    logic        eMon;
    logic [11:0] eBal;
    logic        debited;

    bus.tap_valid = 1'b1;
    bus.tap_id    = id;
    if (admWith) begin
      bus.adm_we      = 1'b1;
      bus.adm_id      = admId;
      bus.adm_active  = admAct;
      bus.adm_monthly = admMon;
      bus.adm_bal     = admBal;
    end
    tick();
    bus.tap_valid = 1'b0;
    bus.adm_we    = 1'b0;
    if (admWith) begin
      m_act[admId] = admAct;
      m_mon[admId] = admMon;
      m_bal[admId] = admBal;
      checkOutput("adm_err_tap", bus.adm_err, 0);
    end
    eAct = m_act[id];
    eMon = m_mon[id];
    eBal = m_bal[id];

    checkOutput("busy_lookup", bus.busy, 1);
    checkOutput("nfc_lookup", bus.nfc, 0);
    if (earlyReduce) bus.reduce_bal = 1'b1;
    tick();
    checkOutput("nfc_present", bus.nfc, 1);
    checkOutput("active_present", bus.card_active, eAct);
    checkOutput("monthly_present", bus.monthly, eMon);
    checkOutput("fund_present", bus.fund_enough, eAct && (eBal >= FARE));
    checkOutput("bal_present", bus.bal_out, eBal);
    tick();
    bus.reduce_bal = 1'b0;
    checkOutput("nfc_wait", bus.nfc, 0);

    debited = 1'b0;
    for (int w = 0; w < TIMEOUT; w++) begin
      checkOutput("busy_wait", bus.busy, 1);
      checkOutput("active_wait", bus.card_active, eAct);
      if (disturb && w == 1) begin
        bus.tap_valid   = 1'b1;
        bus.tap_id      = id + 4'd1;
        bus.adm_we      = 1'b1;
        bus.adm_id      = id;
        bus.adm_active  = 1'b1;
        bus.adm_monthly = 1'b0;
        bus.adm_bal     = 12'hFFF;
      end
      if (w == reduceAt) bus.reduce_bal = 1'b1;
      tick();
      bus.tap_valid  = 1'b0;
      bus.adm_we     = 1'b0;
      bus.reduce_bal = 1'b0;
      if (disturb && w == 1) begin
        checkOutput("tap_drop_pulse", bus.tap_drop, 1);
        checkOutput("adm_err_pulse", bus.adm_err, 1);
      end
      if (w == reduceAt) begin
        debited = 1'b1;
        break;
      end
    end

    if (debited) begin
      checkOutput("busy_debit", bus.busy, 1);
      checkOutput("fund_debit", bus.fund_enough, eAct && (eBal >= FARE));
      tick();
      if (eAct && !eMon && eBal >= FARE) m_bal[id] = eBal - FARE;
    end
    checkIdle("end", m_bal[id]);
  endtask

  function automatic logic [11:0] pickBal();
    case ($urandom_range(0, 5))
      0:       return 12'd0;
      1:       return FARE - 12'd1;
      2:       return FARE;
      3:       return FARE + 12'd1;
      4:       return 12'd500;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    compared        = 0;
    mismatched      = 0;
    reset           = 1'b1;
    bus.tap_valid   = 1'b0;
    bus.tap_id      = '0;
    bus.reduce_bal  = 1'b0;
    bus.adm_we      = 1'b0;
    bus.adm_id      = '0;
    bus.adm_active  = 1'b0;
    bus.adm_monthly = 1'b0;
    bus.adm_bal     = '0;
    modelReset();
    tick();
    tick();
    checkIdle("reset", 12'd0);
    reset = 1'b0;
    tick();

    $display("[TB] directed scenarios");
    adminWrite(4'd3, 1'b1, 1'b0, 12'd1000);
    applyStimulus(4'd3, 2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);
    checkOutput("id3_bal_750", bus.bal_out, 750);
    applyStimulus(4'd3, -1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);

    adminWrite(4'd4, 1'b1, 1'b0, 12'd250);
    applyStimulus(4'd4, 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);
    checkOutput("boundary_bal_0", bus.bal_out, 0);
    applyStimulus(4'd4, 1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);

    adminWrite(4'd9, 1'b1, 1'b1, 12'd100);
    applyStimulus(4'd9, 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);
    checkOutput("monthly_bal_100", bus.bal_out, 100);

    applyStimulus(4'd7, -1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);

    applyStimulus(4'd3, -1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);
    applyStimulus(4'd3, TIMEOUT - 1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);
    checkOutput("id3_bal_500", bus.bal_out, 500);

    applyStimulus(4'd10, 0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 12'd600);
    checkOutput("same_cycle_adm_tap", bus.bal_out, 350);

    // Reset while the ledger sits in DEBIT.
    adminWrite(4'd5, 1'b1, 1'b0, 12'd900);
    bus.tap_valid = 1'b1;
    bus.tap_id    = 4'd5;
    tick();
    bus.tap_valid = 1'b0;
    tick();
    tick();
    bus.reduce_bal = 1'b1;
    tick();
    bus.reduce_bal = 1'b0;
    checkOutput("in_debit_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelReset();
    checkIdle("reset_debit", 12'd0);
    applyStimulus(4'd5, 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'd0);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      logic [3:0] id;
      logic [3:0] aid;
      int         ra;
      bit         admWith;
      id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        adminWrite(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 3) == 0), pickBal());
      end
      admWith = ($urandom_range(0, 3) == 0);
      aid     = ($urandom_range(0, 1) == 0) ? id : 4'($urandom_range(0, 15));
      ra      = $urandom_range(0, TIMEOUT + 2);
      if (ra >= TIMEOUT) ra = -1;
      applyStimulus(id, ra, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
                    admWith, aid, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) == 0), pickBal());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fare_ledger.md
FARE_LEDGER -- requirements
Module: fare_ledger

Interface
REQ-001 Parameters, each: name, default, meaning.
  - FARE, 12'd250, debit per ride (cents).
  - TIMEOUT, 8, cycles to wait for reduce_bal after nfc.
  - NACC, 16, account table depth.
REQ-002 Ports, each: name, direction, width, meaning.
  - clk  in  1  single clock, all logic on posedge.
  - reset  in  1  synchronous, active-high.
  - tap_valid  in  1  card read strobe from NFC reader.
  - tap_id  in  4  account index of tapped card.
  - reduce_bal  in  1  debit request pulse from gate FSM.
  - adm_we  in  1  admin account write strobe.
  - adm_id  in  4  admin target account.
  - adm_active  in  1  admin active flag.
  - adm_monthly  in  1  admin monthly flag.
  - adm_bal  in  12  admin balance.
  - nfc  out  1  one-cycle tap pulse to gate FSM.
  - card_active  out  1  account exists/active.
  - monthly  out  1  monthly pass.
  - fund_enough  out  1  balance >= FARE.
  - bal_out  out  12  balance of current card.
  - busy  out  1  transaction in progress.
  - tap_drop  out  1  one-cycle pulse, tap ignored.
  - adm_err  out  1  one-cycle pulse, admin write refused.

Function
REQ-003 States: IDLE, LOOKUP, PRESENT, WAIT, DEBIT; busy=1 in every state except IDLE.
REQ-004 IDLE: tap_valid=1 latches tap_id, goes to LOOKUP next cycle.
REQ-005 LOOKUP: reads table entry for latched id, registers active/monthly/balance, then goes to PRESENT.
REQ-006 PRESENT: nfc=1 for exactly this cycle, then goes to WAIT; nfc rises 2 cycles after the accepted tap_valid.
REQ-007 card_active, monthly, fund_enough, bal_out are driven from registers set at LOOKUP exit.
  - Stable from the PRESENT cycle until the next IDLE; 0 while in IDLE, except bal_out, which holds its last value.
REQ-008 fund_enough = active & (balance >= FARE), unsigned 12-bit compare; equality counts as enough.
REQ-009 WAIT: a 4-bit counter counts cycles; reduce_bal=1 goes to DEBIT.
  - Counter reaching TIMEOUT without reduce_bal returns to IDLE with no table change.
REQ-010 DEBIT, one cycle: for active non-monthly account with balance >= FARE, write balance-FARE to the table and to bal_out; then go to IDLE.
REQ-011 DEBIT with monthly=1, active=0, or balance < FARE writes nothing; no underflow, no wrap.
REQ-012 reduce_bal outside WAIT is ignored.
REQ-013 tap_valid while busy=1 is dropped and pulses tap_drop for one cycle; the current transaction is unaffected.
REQ-014 adm_we is accepted only in IDLE: writes {adm_active, adm_monthly, adm_bal} to adm_id in that cycle.
  - adm_we while busy=1 is refused with a one-cycle adm_err pulse.
REQ-015 adm_we and tap_valid in the same IDLE cycle:
  - The write commits first.
  - The tap proceeds; LOOKUP reads the written value when adm_id == tap_id.

Reset
REQ-016 reset=1 at a clock edge forces IDLE and clears all counters and registered outputs to 0, including bal_out, nfc, tap_drop, adm_err.
REQ-017 Reset clears every table entry to active=0, monthly=0, balance=0.
REQ-018 Reset mid-transaction, including DEBIT, aborts with no table write in that cycle.

Structure
REQ-019 Shared package fare_pkg holds:
  - FARE and TIMEOUT defaults;
  - state enum fare_state_t;
  - packed struct acct_t {active, monthly, bal[11:0]}.
REQ-020 The table is one sub-module, fare_acct_rf: NACC x acct_t register file with one synchronous-write port and one read port, cleared by reset.
REQ-021 Outputs come from registers, with no combinational path from inputs to outputs.

Verification
REQ-022 Bench covers these directed scenarios:
  - Admin write id3 {1,0,1000}; tap id3; reduce_bal 3 cycles after nfc -> card_active=1, fund_enough=1, table id3 and bal_out = 750.
  - Account {1,0,250}; tap; reduce_bal -> bal_out=0 (exact boundary).
  - Second tap on that account -> fund_enough=0; reduce_bal causes no write; balance stays 0.
  - Monthly account {1,1,100}; tap; reduce_bal -> monthly=1, balance unchanged at 100.
  - Inactive id7; tap; no reduce_bal -> card_active=0, return to IDLE 8 cycles after entering WAIT.
  - Tap during WAIT -> tap_drop pulse; adm_we during WAIT -> adm_err pulse, table unchanged; reset asserted in DEBIT -> IDLE, no debit.
